// File: rtl/u409_pkg.sv
// U409 flash command sequencer shared types.
// JEDEC unlock offsets, command bytes, opcodes and FSM states.
package u409_pkg;

  localparam logic [22:0] FLASH_BASE = 23'h780000;
  localparam logic [22:0] OFS_555 = 23'h000555;
  localparam logic [22:0] OFS_2AA = 23'h0002AA;

  localparam int unsigned ACK_TIMEOUT_DEF = 15;
  localparam int unsigned RDY_SETTLE_DEF = 4;
  localparam int unsigned RDY_TIMEOUT_DEF = 8_000_000;

  localparam logic [7:0] CMD_AA = 8'hAA;
  localparam logic [7:0] CMD_55 = 8'h55;
  localparam logic [7:0] CMD_A0 = 8'hA0;
  localparam logic [7:0] CMD_80 = 8'h80;
  localparam logic [7:0] CMD_30 = 8'h30;
  localparam logic [7:0] CMD_10 = 8'h10;

  typedef enum logic [1:0] {
    OP_PROG = 2'b00,
    OP_SECT = 2'b01,
    OP_CHIP = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SEL_555,
    SEL_2AA,
    SEL_ADDR
  } sel_e;

  typedef struct packed {
    sel_e       sel;
    logic       use_wd;
    logic [7:0] cmd;
    logic       last;
  } rom_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_GAP,
    ST_SETTLE,
    ST_POLL,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/u409_flash_cmd_rom.sv
// Command table: (op, step) to address select, data byte and last flag.
// Program is 4 writes; sector and chip erase are 6.
module u409_flash_cmd_rom
  import u409_pkg::*;
(
  input  op_e        op,
  input  logic [2:0] step,
  output rom_t       ent
);

  always_comb begin
    ent.sel = SEL_555;
    ent.use_wd = 1'b0;
    ent.cmd = CMD_AA;
    ent.last = 1'b0;
    unique case (step)
      3'd0: ent.cmd = CMD_AA;
      3'd1: begin
        ent.sel = SEL_2AA;
        ent.cmd = CMD_55;
      end
      3'd2: ent.cmd = (op == OP_PROG) ? CMD_A0 : CMD_80;
      3'd3: begin
        if (op == OP_PROG) begin
          ent.sel = SEL_ADDR;
          ent.use_wd = 1'b1;
          ent.last = 1'b1;
        end
      end
      3'd4: begin
        ent.sel = SEL_2AA;
        ent.cmd = CMD_55;
      end
      3'd5: begin
        ent.last = 1'b1;
        if (op == OP_CHIP) begin
          ent.cmd = CMD_10;
        end else begin
          ent.sel = SEL_ADDR;
          ent.cmd = CMD_30;
        end
      end
      default: ent.last = 1'b1;
    endcase
  end

endmodule

// File: rtl/u409_flash_cmd.sv
// Flash command sequencer: issues JEDEC write cycles to the
// U409 flash responder, then polls FLASH_RDY for completion.
module u409_flash_cmd
  import u409_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int unsigned RDY_SETTLE = RDY_SETTLE_DEF,
  parameter int unsigned RDY_TIMEOUT = RDY_TIMEOUT_DEF
) (
  input  logic        CLK40,
  input  logic        RESET,
  input  logic        START,
  input  logic [1:0]  OP,
  input  logic [22:0] ADDR,
  input  logic [15:0] WDATA,
  input  logic        FLASH_TACK,
  input  logic        FLASH_RDY,
  output logic        TSn,
  output logic        RnW,
  output logic [22:0] A,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR
);

  localparam logic [23:0] ACK_LIM = 24'(ACK_TIMEOUT - 1);
  localparam logic [23:0] SET_LIM = 24'(RDY_SETTLE - 1);
  localparam logic [23:0] RDY_LIM = 24'(RDY_TIMEOUT - 1);

  state_e      state;
  op_e         op_q;
  logic [22:0] addr_q;
  logic [15:0] wdata_q;
  logic [2:0]  step;
  logic        last_q;
  logic [23:0] cnt;
  logic [23:0] cnt_inc;

  op_e         rom_op;
  logic [2:0]  rom_step;
  rom_t        ent;
  logic [22:0] src_addr;
  logic [15:0] src_wd;
  logic [22:0] cyc_addr;
  logic [15:0] cyc_data;
  logic        start_ok;

  // Idle looks up step 0 straight from the inputs so TSn
  // can fall on the clock after START.
  always_comb begin
    if (state == ST_GAP) begin
      rom_op = op_q;
      rom_step = step + 3'd1;
      src_addr = addr_q;
      src_wd = wdata_q;
    end else begin
      rom_op = op_e'(OP);
      rom_step = 3'd0;
      src_addr = ADDR;
      src_wd = WDATA;
    end
  end

  u409_flash_cmd_rom u_rom (
    .op   (rom_op),
    .step (rom_step),
    .ent  (ent)
  );

  always_comb begin
    unique case (ent.sel)
      SEL_555: cyc_addr = FLASH_BASE | OFS_555;
      SEL_2AA: cyc_addr = FLASH_BASE | OFS_2AA;
      default: cyc_addr = src_addr;
    endcase
    cyc_data = ent.use_wd ? src_wd : {8'h00, ent.cmd};
  end

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 24'd1;
  assign start_ok = START && (op_e'(OP) != OP_RSVD);

  always_ff @(posedge CLK40) begin
    if (RESET) begin
      state <= ST_IDLE;
      op_q <= OP_PROG;
      addr_q <= '0;
      wdata_q <= '0;
      step <= '0;
      last_q <= 1'b0;
      cnt <= '0;
      TSn <= 1'b1;
      RnW <= 1'b1;
      A <= '0;
      D_OUT <= '0;
      D_OE <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      ERROR <= 1'b0;
    end else begin
      DONE <= 1'b0;
      TSn <= 1'b1;
      unique case (state)
        ST_IDLE, ST_FINISH: begin
          state <= ST_IDLE;
          if (start_ok) begin
            op_q <= op_e'(OP);
            addr_q <= ADDR;
            wdata_q <= WDATA;
            step <= 3'd0;
            ERROR <= 1'b0;
            BUSY <= 1'b1;
            RnW <= 1'b0;
            TSn <= 1'b0;
            A <= cyc_addr;
            D_OUT <= cyc_data;
            D_OE <= 1'b1;
            last_q <= ent.last;
            state <= ST_ISSUE;
          end else if (START) begin
            DONE <= 1'b1;
            ERROR <= 1'b1;
          end
        end
        ST_ISSUE: begin
          cnt <= 24'd1;
          state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (FLASH_TACK) begin
            D_OE <= 1'b0;
            cnt <= '0;
            state <= ST_GAP;
          end else if (cnt >= ACK_LIM) begin
            D_OE <= 1'b0;
            ERROR <= 1'b1;
            DONE <= 1'b1;
            BUSY <= 1'b0;
            RnW <= 1'b1;
            state <= ST_FINISH;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_GAP: begin
          if (cnt == 24'd1) begin
            cnt <= '0;
            if (last_q) begin
              state <= ST_SETTLE;
            end else begin
              step <= step + 3'd1;
              TSn <= 1'b0;
              A <= cyc_addr;
              D_OUT <= cyc_data;
              D_OE <= 1'b1;
              last_q <= ent.last;
              state <= ST_ISSUE;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_SETTLE: begin
          if (cnt >= SET_LIM) begin
            cnt <= '0;
            state <= ST_POLL;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_POLL: begin
          if (FLASH_RDY || cnt >= RDY_LIM) begin
            ERROR <= !FLASH_RDY;
            DONE <= 1'b1;
            BUSY <= 1'b0;
            RnW <= 1'b1;
            state <= ST_FINISH;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
